secuenciador_melodia: RTL
=========================

// Module: secuenciador_melodia
// PURPOSE
//  Upstream stage of the note lookup table. Steps the 5-bit note index through the song at a fixed
//  tempo and inserts a short silent gap between notes so repeated notes are audible.
//  Provides play/stop/pause control, optional looping, and an end-of-song pulse.
//  The index drives the lookup table; mute gates the downstream tone generator.
// PARAMETERS
//  CLOCK_FREQUENCY  12000000  system clock in Hz; documentation only, no logic depends on it
//  NOTE_CYCLES      3000000   clocks each note is sounded (250 ms at 12 MHz); must be >= 1
//  GAP_CYCLES       300000    clocks of silence after each note (25 ms); 0 = no gap
//  LAST_INDEX       29        index of the silent table entry; song = indices 0..LAST_INDEX-1
// PORTS
//  clk      in   1  system clock, rising edge
//  rst      in   1  asynchronous, active-high reset
//  play     in   1  1-cycle pulse; starts the song at index 0 (restarts if already playing)
//  stop     in   1  1-cycle pulse; aborts playback and returns to idle
//  pausa    in   1  level; while high, playback freezes and output is muted
//  loop_en  in   1  level; sampled at the end of the last note's gap
//  i        out  5  note index to the lookup table (registered)
//  mute     out  1  1 = silence the tone generator (registered)
//  playing  out  1  1 while in NOTE or GAP (registered)
//  fin      out  1  1-cycle pulse at natural end of song when not looping (registered)
// BEHAVIOUR
//  Reset (async, takes effect immediately): state IDLE, i=LAST_INDEX, mute=1, playing=0, fin=0, cnt=0.
//  Counter cnt: width $clog2(max(NOTE_CYCLES,GAP_CYCLES)+1); counts clocks within NOTE or GAP; never wraps.
//  States: IDLE, NOTE, GAP. All outputs are registered; a change in state appears on outputs 1 cycle after the input edge.
//  Priority, highest first: rst > stop > play > pausa > normal timing.
//  IDLE: i=LAST_INDEX, mute=1, playing=0. On play: go to NOTE, i=0, cnt=0, mute=0, playing=1.
//  NOTE: mute=0; cnt increments each clock.
//    At cnt==NOTE_CYCLES-1 with GAP_CYCLES>0: go to GAP, cnt=0, mute=1.
//    At cnt==NOTE_CYCLES-1 with GAP_CYCLES==0: apply the advance rule directly.
//  GAP: mute=1; cnt increments. At cnt==GAP_CYCLES-1, apply the advance rule.
//  Advance rule:
//    If i<LAST_INDEX-1: i=i+1, go to NOTE, cnt=0, mute=0.
//    If i==LAST_INDEX-1 and loop_en=1: i=0, go to NOTE; no fin pulse.
//    If i==LAST_INDEX-1 and loop_en=0: go to IDLE, i=LAST_INDEX, mute=1, playing=0, fin=1 for exactly 1 cycle.
//  play while in NOTE or GAP: restart at i=0 in NOTE, cnt=0; no fin pulse.
//  stop in any state: next cycle IDLE, i=LAST_INDEX, mute=1, playing=0, cnt=0; no fin. stop+play same cycle -> stop wins.
//  pausa=1 in NOTE/GAP: cnt, i and state hold; mute=1; playing stays 1.
//    On release: resume the remaining count; mute returns to the state's value the next cycle.
//  pausa has no effect in IDLE; play during pausa still restarts (song frozen at i=0 until pausa drops).
//  Song length (no pause): LAST_INDEX*(NOTE_CYCLES+GAP_CYCLES) clocks from play to fin.
//  Never outputs i>LAST_INDEX. No combinational path from inputs to outputs.
// TESTING (bench params NOTE_CYCLES=4, GAP_CYCLES=2, LAST_INDEX=29)
//  Reset mid-song at arbitrary time -> same cycle: i=29, mute=1, playing=0, fin=0; stays idle with no play.
//  play at cycle 0, loop_en=0 -> i=0 mute=0 cycles 1-4; mute=1 cycles 5-6; i=1 mute=0 at cycle 7;
//    fin=1 only at cycle 175, i=29, playing=0.
//  Same with loop_en=1 -> at cycle 175 i=0, mute=0; no fin pulse; sequence repeats identically.
//  pausa high for 10 cycles starting in the 2nd clock of note 3 -> i stays 3, mute=1;
//    after release, note 3 sounds 3 more clocks; fin delayed by exactly 10 cycles.
//  stop and play asserted together at i=12 -> idle, i=29, fin never pulses.
//    Separate play at i=12 -> i=0, cnt restarted.
//  GAP_CYCLES=0 variant -> mute stays 0 from i=0 to i=28, index advances every 4 clocks, fin at cycle 117.

Source files
------------

// File: rtl/secuenciador_melodia_if.sv
// rtl/secuenciador_melodia_if.sv - control inputs and note outputs of the melody sequencer
interface secuenciador_melodia_if;
   logic       play;
   logic       stop;
   logic       pausa;
   logic       loop_en;
   logic [4:0] i;
   logic       mute;
   logic       playing;
   logic       fin;

   modport master (output play, stop, pausa, loop_en, input i, mute, playing, fin);
   modport slave  (input play, stop, pausa, loop_en, output i, mute, playing, fin);
endinterface

// File: rtl/secuenciador_melodia.sv
// rtl/secuenciador_melodia.sv - steps the note index at a fixed tempo with a silent gap between notes
module secuenciador_melodia #(
   parameter int CLOCK_FREQUENCY = 12000000,
   parameter int NOTE_CYCLES     = 3000000,
   parameter int GAP_CYCLES      = 300000,
   parameter int LAST_INDEX      = 29
) (
   input logic                   clk,
   input logic                   rst,
   secuenciador_melodia_if.slave bus
);
   localparam int clock_frequency_unused = CLOCK_FREQUENCY;
   localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] NOTE_END   = CW'(NOTE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_END    = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [4:0]    LAST_I     = 5'(LAST_INDEX);
   localparam logic [4:0]    FINAL_NOTE = 5'(LAST_INDEX - 1);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    i_q, i_d;
   logic          mute_q, mute_d;
   logic          playing_q, playing_d;
   logic          fin_q, fin_d;
   logic          advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         i_q       <= LAST_I;
         mute_q    <= 1'b1;
         playing_q <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         i_q       <= i_d;
         mute_q    <= mute_d;
         playing_q <= playing_d;
         fin_q     <= fin_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      i_d       = i_q;
      mute_d    = mute_q;
      playing_d = playing_q;
      fin_d     = 1'b0;
      advance   = 1'b0;

      if (bus.stop) begin
         state_d   = IDLE;
         cnt_d     = '0;
         i_d       = LAST_I;
         mute_d    = 1'b1;
         playing_d = 1'b0;
      end else if (bus.play) begin
         // A restart under pause stays muted at index 0 until pausa drops.
         state_d   = NOTE;
         cnt_d     = '0;
         i_d       = '0;
         mute_d    = bus.pausa;
         playing_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               i_d       = LAST_I;
               mute_d    = 1'b1;
               playing_d = 1'b0;
            end
            NOTE: begin
               if (bus.pausa) begin
                  mute_d = 1'b1;
               end else if (cnt_q == NOTE_END) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     cnt_d   = '0;
                     mute_d  = 1'b1;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  cnt_d  = cnt_q + 1'b1;
                  mute_d = 1'b0;
               end
            end
            GAP: begin
               mute_d = 1'b1;
               if (!bus.pausa) begin
                  if (cnt_q == GAP_END) advance = 1'b1;
                  else cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (advance) begin
         cnt_d = '0;
         if (i_q < FINAL_NOTE) begin
            state_d = NOTE;
            i_d     = i_q + 1'b1;
            mute_d  = 1'b0;
         end else if (bus.loop_en) begin
            state_d = NOTE;
            i_d     = '0;
            mute_d  = 1'b0;
         end else begin
            state_d   = IDLE;
            i_d       = LAST_I;
            mute_d    = 1'b1;
            playing_d = 1'b0;
            fin_d     = 1'b1;
         end
      end
   end

   assign bus.i       = i_q;
   assign bus.mute    = mute_q;
   assign bus.playing = playing_q;
   assign bus.fin     = fin_q;
endmodule
